// File: rtl/axi4_lite_req_arbiter_if.sv
// rtl/axi4_lite_req_arbiter_if.sv - requester and AXI4-Lite master command bus for the arbiter
interface axi4_lite_req_arbiter_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             start_write;
    logic             start_read;
    logic [31:0]      write_address;
    logic [31:0]      write_data;
    logic [31:0]      read_address;
    logic [31:0]      read_data;
    logic             write_done;
    logic             read_done;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, read_data, write_done, read_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, start_write, start_read,
               write_address, write_data, read_address
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, read_data, write_done, read_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, start_write, start_read,
               write_address, write_data, read_address
    );
endinterface

// File: rtl/axi4_lite_req_arbiter.sv
// rtl/axi4_lite_req_arbiter.sv - two-requester round-robin front end for one AXI4-Lite master
module axi4_lite_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axi4_lite_req_arbiter_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        last_grant_q;
    logic        owner_q;
    logic        is_write_q;
    logic [15:0] timeout_cnt_q;
    logic        start_write_q;
    logic        start_read_q;
    logic [31:0] write_address_q;
    logic [31:0] write_data_q;
    logic [31:0] read_address_q;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        winner;
    logic [1:0]  grant;
    logic        match_done;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        winner = 1'b0;
        case (bus.req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
        grant = 2'b00;
        if (rst_n && (state_q == IDLE) && (|bus.req_valid)) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

    assign match_done = is_write_q ? bus.write_done : bus.read_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b1;
            owner_q         <= 1'b0;
            is_write_q      <= 1'b0;
            timeout_cnt_q   <= '0;
            start_write_q   <= 1'b0;
            start_read_q    <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            read_address_q  <= '0;
            rsp_valid_q     <= 2'b00;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
            rsp_valid_q   <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        owner_q      <= winner;
                        last_grant_q <= winner;
                        is_write_q   <= bus.req_write[winner];
                        if (bus.req_write[winner]) begin
                            write_address_q <= bus.req_addr[winner];
                            write_data_q    <= bus.req_wdata[winner];
                            start_write_q   <= 1'b1;
                        end else begin
                            read_address_q  <= bus.req_addr[winner];
                            start_read_q    <= 1'b1;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    timeout_cnt_q <= '0;
                    state_q       <= WAIT;
                end
                WAIT: begin
                    // A matching done wins over the timeout threshold in the same cycle.
                    if (match_done) begin
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= is_write_q ? 32'h0 : bus.read_data;
                        state_q     <= RESP;
                    end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                        state_q     <= RESP;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = grant;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.start_write   = start_write_q;
    assign bus.start_read    = start_read_q;
    assign bus.write_address = write_address_q;
    assign bus.write_data    = write_data_q;
    assign bus.read_address  = read_address_q;
endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// tb/tb_axi4_lite_req_arbiter.sv - directed self-checking bench for axi4_lite_req_arbiter
module tb_axi4_lite_req_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    axi4_lite_req_arbiter_if bus();

    axi4_lite_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 2 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int  k;
        logic early;
        logic seen;
        logic [1:0] exp_ready;

        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.read_data = '0;
        bus.write_done = 1'b0;
        bus.read_done  = 1'b0;

        step();
        step();
        check("rst_req_ready", 64'(bus.req_ready), 64'h0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_starts", 64'({bus.start_write, bus.start_read}), 64'h0);
        check("rst_operands", 64'(bus.write_address | bus.write_data | bus.read_address), 64'h0);
        check("rst_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'h0);
        rst_n = 1'b1;
        step();

        // Single write from requester 0, write_done two cycles after start_write.
        bus.req_valid    = 2'b01;
        bus.req_write    = 2'b01;
        bus.req_addr[0]  = 32'h10;
        bus.req_wdata[0] = 32'hA5A5A5A5;
        #1;
        check("wr_ready", 64'(bus.req_ready), 64'h1);
        step();
        bus.req_valid = 2'b00;
        check("wr_start", 64'({bus.start_write, bus.start_read}), 64'h2);
        check("wr_addr", 64'(bus.write_address), 64'h10);
        check("wr_data", 64'(bus.write_data), 64'hA5A5A5A5);
        step();
        check("wr_start_gone", 64'(bus.start_write), 64'h0);
        step();
        bus.write_done = 1'b1;
        step();
        bus.write_done = 1'b0;
        check("wr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("wr_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'h0);
        step();
        check("wr_rsp_pulse", 64'(bus.rsp_valid), 64'h0);

        // Single read from requester 1 at minimum latency.
        bus.req_valid   = 2'b10;
        bus.req_write   = 2'b00;
        bus.req_addr[1] = 32'h20;
        bus.read_data   = 32'hDEADBEEF;
        #1;
        check("rd_ready", 64'(bus.req_ready), 64'h2);
        step();
        bus.req_valid = 2'b00;
        check("rd_start", 64'({bus.start_write, bus.start_read}), 64'h1);
        check("rd_addr", 64'(bus.read_address), 64'h20);
        check("rd_wr_hold", 64'(bus.write_address), 64'h10);
        step();
        bus.read_done = 1'b1;
        step();
        bus.read_done = 1'b0;
        check("rd_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        check("rd_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'hDEADBEEF);
        step();
        check("rd_rdata_hold", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'hDEADBEEF);

        // Contention straight out of reset: grants alternate 0,1,0,1.
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        bus.req_addr[0] = 32'h100;
        bus.req_addr[1] = 32'h200;
        #1;
        check("ct_rst_ready", 64'(bus.req_ready), 64'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check("ct_ready", 64'(bus.req_ready), 64'(exp_ready));
            step();
            check("ct_ready_busy", 64'(bus.req_ready), 64'h0);
            check("ct_rd_addr", 64'(bus.read_address), (i % 2 == 0) ? 64'h100 : 64'h200);
            step();
            bus.read_done = 1'b1;
            bus.read_data = 32'h1000 + 32'(i);
            step();
            bus.read_done = 1'b0;
            check("ct_rsp_valid", 64'(bus.rsp_valid), 64'(exp_ready));
            check("ct_rdata", 64'(bus.rsp_rdata), 64'h1000 + 64'(i));
            step();
        end

        // Timeout read with a non-matching write_done held throughout WAIT.
        bus.req_valid   = 2'b01;
        bus.req_write   = 2'b00;
        bus.req_addr[0] = 32'h30;
        #1;
        check("to_ready", 64'(bus.req_ready), 64'h1);
        step();
        bus.req_valid = 2'b00;
        check("to_start", 64'({bus.start_write, bus.start_read}), 64'h1);
        step();
        bus.write_done = 1'b1;
        k = 0;
        while (bus.rsp_valid == 2'b00 && k < 20) begin
            step();
            k++;
        end
        bus.write_done = 1'b0;
        check("to_latency", 64'(k), 64'd8);
        check("to_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("to_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'h100000000);
        step();

        // Write with read_done ignored, write_done on the threshold cycle.
        bus.req_valid    = 2'b10;
        bus.req_write    = 2'b10;
        bus.req_addr[1]  = 32'h40;
        bus.req_wdata[1] = 32'h12345678;
        #1;
        check("th_ready", 64'(bus.req_ready), 64'h2);
        step();
        bus.req_valid = 2'b00;
        check("th_start", 64'({bus.start_write, bus.start_read}), 64'h2);
        check("th_wdata", 64'(bus.write_data), 64'h12345678);
        step();
        bus.read_done = 1'b1;
        early = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step();
            if (bus.rsp_valid != 2'b00) early = 1'b1;
        end
        bus.write_done = 1'b1;
        step();
        bus.write_done = 1'b0;
        bus.read_done  = 1'b0;
        check("th_no_early", 64'(early), 64'h0);
        check("th_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        check("th_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'h0);
        step();

        // Reset in WAIT abandons the write; a later write_done is ignored.
        bus.req_valid    = 2'b01;
        bus.req_write    = 2'b01;
        bus.req_addr[0]  = 32'h50;
        bus.req_wdata[0] = 32'h55;
        step();
        bus.req_valid = 2'b00;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mr_operands", 64'(bus.write_address | bus.write_data | bus.read_address), 64'h0);
        check("mr_outputs", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.start_write, bus.start_read}), 64'h0);
        check("mr_rdata", 64'(bus.rsp_rdata), 64'h0);
        step();
        rst_n = 1'b1;
        bus.write_done = 1'b1;
        step();
        bus.write_done = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (bus.rsp_valid != 2'b00) seen = 1'b1;
            step();
        end
        check("mr_no_rsp", 64'(seen), 64'h0);
        bus.req_valid   = 2'b10;
        bus.req_write   = 2'b00;
        bus.req_addr[1] = 32'h60;
        bus.read_data   = 32'hCAFEF00D;
        #1;
        check("mr_ready", 64'(bus.req_ready), 64'h2);
        step();
        bus.req_valid = 2'b00;
        check("mr_rd_addr", 64'(bus.read_address), 64'h60);
        step();
        bus.read_done = 1'b1;
        step();
        bus.read_done = 1'b0;
        check("mr_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        check("mr_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'hCAFEF00D);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
